// File: rtl/multicycle_controller_if.sv
// Instruction/status bus between the datapath and the multicycle control FSM.
// The controller takes the slave side; the datapath (or bench) takes the master side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic       illegal;
    logic       mem_timeout;

    modport master (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
        input  state, illegal, mem_timeout
    );

    modport slave (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
        output state, illegal, mem_timeout
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control unit: Moore FSM, ALU decoder, immediate select,
// and a sticky memory-stall watchdog.
module multicycle_controller #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam int unsigned     CW      = (WAIT_MAX == 0) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(WAIT_MAX);
    localparam bit              TO_EN   = (WAIT_MAX != 0);

    state_e          state_q, state_d;
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            timeout_q, timeout_d;

    logic            pc_update;
    logic            branch;
    logic [1:0]      alu_op;
    logic            stall;

    // State register and stall watchdog
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_MEMWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_ALUWB:    state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore outputs; FETCH qualifies its strobes with mem_ready so a stall holds them low
    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        alu_op        = 2'b00;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.IRWrite   = bus.mem_ready;
                pc_update     = bus.mem_ready;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            S_EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = 2'b10;
            end
            S_EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                alu_op      = 2'b10;
            end
            S_ALUWB:    bus.RegWrite = 1'b1;
            S_JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                pc_update   = 1'b1;
            end
            S_BEQ: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = 2'b01;
                branch      = 1'b1;
            end
            S_TRAP:     bus.illegal = 1'b1;
            default: ;
        endcase
    end

    assign bus.PCWrite = pc_update | (branch & bus.Zero);

    // ALU decoder; op[5] separates R-type SUB from I-type ADDI with bit 30 set
    always_comb begin
        bus.ALUControl = ALU_ADD;
        case (alu_op)
            2'b01: bus.ALUControl = ALU_SUB;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.op[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  bus.ALUControl = ALU_SLT;
                    3'b110:  bus.ALUControl = ALU_OR;
                    3'b111:  bus.ALUControl = ALU_AND;
                    default: bus.ALUControl = ALU_ADD;
                endcase
            end
            default: bus.ALUControl = ALU_ADD;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    // Stall watchdog: completion on the reaching cycle is not a stall, so it never trips
    assign stall = ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE))
                   && !bus.mem_ready;

    always_comb begin
        stall_cnt_d = '0;
        if (stall)
            stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CW'(1);
        timeout_d = timeout_q | (TO_EN && stall && (stall_cnt_d == CNT_MAX));
    end

    assign bus.state       = state_q;
    assign bus.mem_timeout = timeout_q;

endmodule
